// File: rtl/rdy_seq_pkg.sv
// Shared types and widths for the 6502 RDY sequencer.
package rdy_seq_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PEND  = 2'd1,
    ST_STALL = 2'd2
  } state_e;

  localparam int unsigned WCNT_W = 2;
  localparam int unsigned DLY_W  = 4;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, with registered
// one-clock rise/fall pulses taken from the last stage and one extra flop.
module sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;
  logic              rise_q;
  logic              fall_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      last_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      last_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~last_q;
      fall_q <= ~sync_q[STAGES-1] & last_q;
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/rdy_sequencer.sv
// Qualifies host 8502 RDY into 6502 RDY, letting writes through until the
// first read or write-budget exhaustion. Write pass enabled by RDY_WRITE_PASS_EN.
module rdy_sequencer
  import rdy_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SAMPLE_DLY  = 4,
  parameter int unsigned MAX_WRITES  = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              phi2,
  input  logic              _rdy_host,
  input  logic              r_w,
  output logic              _rdy_cpu,
  output logic              phi2_rise,
  output logic              phi2_fall,
  output logic              stalled,
  output logic [WCNT_W-1:0] write_cnt,
  output logic              overrun
);

  logic             hr;
  logic             phi2_level_unused;
  logic [1:0]       rdy_edges_unused;
  logic [DLY_W-1:0] dly_q;
  logic [DLY_W-1:0] dly_d;
  logic             dp_c;

  state_e            state_q;
  logic              rdy_q;
  logic              stalled_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic              ovr_q;

  sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_phi2_sync (
    .clock   (clock),
    .reset   (reset),
    .d_i     (phi2),
    .level_o (phi2_level_unused),
    .rise_o  (phi2_rise),
    .fall_o  (phi2_fall)
  );

  sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_rdy_sync (
    .clock   (clock),
    .reset   (reset),
    .d_i     (_rdy_host),
    .level_o (hr),
    .rise_o  (rdy_edges_unused[0]),
    .fall_o  (rdy_edges_unused[1])
  );

  // Decision-point timer: reloaded by every phi2 fall, fires once as it hits zero.
  always_comb begin
    dly_d = dly_q;
    if (phi2_fall) begin
      dly_d = DLY_W'(SAMPLE_DLY);
    end else if (dly_q != '0) begin
      dly_d = dly_q - DLY_W'(1);
    end
  end

  assign dp_c = !phi2_fall && (dly_q == DLY_W'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dly_q <= '0;
    end else begin
      dly_q <= dly_d;
    end
  end

`ifndef RDY_WRITE_PASS_EN
  logic rw_unused;
  localparam int unsigned max_writes_unused = MAX_WRITES;
  assign rw_unused = r_w;
`endif

  // All state and outputs move only at the decision point.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_RUN;
      rdy_q     <= 1'b1;
      stalled_q <= 1'b0;
      wcnt_q    <= '0;
      ovr_q     <= 1'b0;
    end else if (dp_c) begin
      case (state_q)
        ST_RUN: begin
          if (!hr) begin
`ifdef RDY_WRITE_PASS_EN
            if (r_w) begin
              state_q   <= ST_STALL;
              rdy_q     <= 1'b0;
              stalled_q <= 1'b1;
            end else begin
              state_q <= ST_PEND;
              wcnt_q  <= WCNT_W'(1);
            end
`else
            state_q   <= ST_STALL;
            rdy_q     <= 1'b0;
            stalled_q <= 1'b1;
`endif
          end
        end
        ST_PEND: begin
`ifdef RDY_WRITE_PASS_EN
          if (hr) begin
            state_q <= ST_RUN;
            wcnt_q  <= '0;
          end else if (r_w) begin
            state_q   <= ST_STALL;
            rdy_q     <= 1'b0;
            stalled_q <= 1'b1;
          end else if (wcnt_q == WCNT_W'(MAX_WRITES)) begin
            state_q   <= ST_STALL;
            rdy_q     <= 1'b0;
            stalled_q <= 1'b1;
            ovr_q     <= 1'b1;
          end else begin
            wcnt_q <= wcnt_q + WCNT_W'(1);
          end
`else
          state_q <= ST_RUN;
`endif
        end
        ST_STALL: begin
          if (hr) begin
            state_q   <= ST_RUN;
            rdy_q     <= 1'b1;
            stalled_q <= 1'b0;
            wcnt_q    <= '0;
          end
        end
        default: begin
          state_q   <= ST_RUN;
          rdy_q     <= 1'b1;
          stalled_q <= 1'b0;
          wcnt_q    <= '0;
        end
      endcase
    end
  end

  assign _rdy_cpu  = rdy_q;
  assign stalled   = stalled_q;
  assign write_cnt = wcnt_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_rdy_sequencer.sv
// Randomized bench for rdy_sequencer against a per-decision-point behavioural model.
module tb_rdy_sequencer;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned SAMPLE_DLY  = 4;
  localparam int unsigned MAX_WRITES  = 3;
  localparam int FALL_K = int'(SYNC_STAGES) + 1;
  localparam int DP_K   = FALL_K + int'(SAMPLE_DLY) + 1;
`ifdef RDY_WRITE_PASS_EN
  localparam bit WPASS = 1'b1;
`else
  localparam bit WPASS = 1'b0;
`endif

  logic       clock     = 1'b0;
  logic       reset     = 1'b0;
  logic       phi2      = 1'b1;
  logic       _rdy_host = 1'b1;
  logic       r_w       = 1'b1;
  logic       _rdy_cpu;
  logic       phi2_rise;
  logic       phi2_fall;
  logic       stalled;
  logic [1:0] write_cnt;
  logic       overrun;

  int checks   = 0;
  int failures = 0;

  bit m_stalled = 1'b0;
  int m_wcnt    = 0;
  bit m_ovr     = 1'b0;

  rdy_sequencer #(
    .SYNC_STAGES (SYNC_STAGES),
    .SAMPLE_DLY  (SAMPLE_DLY),
    .MAX_WRITES  (MAX_WRITES)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .phi2      (phi2),
    ._rdy_host (_rdy_host),
    .r_w       (r_w),
    ._rdy_cpu  (_rdy_cpu),
    .phi2_rise (phi2_rise),
    .phi2_fall (phi2_fall),
    .stalled   (stalled),
    .write_cnt (write_cnt),
    .overrun   (overrun)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Write budget view: a write with host not ready spends one slot; a read,
  // or a write once the budget is spent, stalls the CPU until host is ready.
  function automatic void model_dp(input bit host_rdy, input bit rd);
    if (host_rdy) begin
      m_stalled = 1'b0;
      m_wcnt    = 0;
    end else if (!m_stalled) begin
      if (!WPASS || rd) begin
        m_stalled = 1'b1;
      end else if (m_wcnt == int'(MAX_WRITES)) begin
        m_stalled = 1'b1;
        m_ovr     = 1'b1;
      end else begin
        m_wcnt++;
      end
    end
  endfunction

  // One host phi2 cycle: phi2 falls, host RDY/R-W set for phi1, optional
  // host RDY flip during phi2 high that must not be seen before the next DP.
  task automatic bus_cycle(input bit rdy_v, input bit rw_v, input bit mid);
    int lo;
    int hi;
    int tog;
    lo  = DP_K + int'($urandom_range(2, 4));
    hi  = int'($urandom_range(8, 10));
    tog = int'($urandom_range(1, 4));
    @(posedge clock);
    #3;
    phi2      = 1'b0;
    _rdy_host = rdy_v;
    r_w       = rw_v;
    for (int k = 1; k <= lo + hi; k++) begin
      @(posedge clock);
      #1;
      if (k == DP_K) begin
        model_dp(rdy_v, rw_v);
        check_eq("write_cnt", int'(write_cnt), m_wcnt);
        check_eq("overrun", int'(overrun), int'(m_ovr));
      end
      check_eq("rdy_cpu", int'(_rdy_cpu), int'(!m_stalled));
      check_eq("stalled", int'(stalled), int'(m_stalled));
      check_eq("phi2_fall", int'(phi2_fall), int'(k == FALL_K));
      check_eq("phi2_rise", int'(phi2_rise), int'(k == lo + FALL_K));
      #2;
      if (k == lo) begin
        phi2 = 1'b1;
        r_w  = 1'($urandom);
      end
      if (mid && k == lo + tog) _rdy_host = !rdy_v;
    end
  endtask

  task automatic apply_reset();
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check_eq("rst_rdy_cpu", int'(_rdy_cpu), 1);
    check_eq("rst_stalled", int'(stalled), 0);
    check_eq("rst_write_cnt", int'(write_cnt), 0);
    check_eq("rst_overrun", int'(overrun), 0);
    check_eq("rst_phi2_fall", int'(phi2_fall), 0);
    m_stalled = 1'b0;
    m_wcnt    = 0;
    m_ovr     = 1'b0;
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b0;
    repeat (SYNC_STAGES + 4) @(posedge clock);
  endtask

  initial begin
    apply_reset();

    // Read with host not ready, then release.
    bus_cycle(1'b0, 1'b1, 1'b0);
    bus_cycle(1'b1, 1'b1, 1'b0);

    // W, W, R with host not ready, then release.
    bus_cycle(1'b0, 1'b0, 1'b0);
    bus_cycle(1'b0, 1'b0, 1'b0);
    bus_cycle(1'b0, 1'b1, 1'b0);
    bus_cycle(1'b1, 1'b0, 1'b0);

    // Four writes exhaust the budget; overrun must persist after release.
    repeat (4) bus_cycle(1'b0, 1'b0, 1'b0);
    bus_cycle(1'b1, 1'b1, 1'b0);

    // Host RDY returns mid-phi2 while stalled: release only at next DP.
    bus_cycle(1'b0, 1'b1, 1'b1);
    bus_cycle(1'b1, 1'b1, 1'b0);

    // Reset while stalled (with overrun in write-pass builds).
    repeat (4) bus_cycle(1'b0, 1'b0, 1'b0);
    apply_reset();
    bus_cycle(1'b1, 1'b0, 1'b0);
    bus_cycle(1'b0, 1'b0, 1'b0);

    repeat (40) bus_cycle(1'($urandom), 1'($urandom), 1'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
